// File: rtl/axis_pack_24to32_if.sv
// AXI-Stream handshake bundle for the 24-to-32 bit packer.
// slave is the packer side; master is the upstream/downstream environment side.
interface axis_pack_24to32_if;
  logic        s_axis_tvalid;
  logic        s_axis_tready;
  logic [23:0] s_axis_tdata;
  logic        m_axis_tvalid;
  logic        m_axis_tready;
  logic [31:0] m_axis_tdata;

  modport slave (
    input  s_axis_tvalid, s_axis_tdata, m_axis_tready,
    output s_axis_tready, m_axis_tvalid, m_axis_tdata
  );

  modport master (
    output s_axis_tvalid, s_axis_tdata, m_axis_tready,
    input  s_axis_tready, m_axis_tvalid, m_axis_tdata
  );
endinterface

// File: rtl/axis_pack_24to32.sv
// Packs 24-bit AXI-Stream beats into dense 32-bit words (4 beats -> 3 words, first pixel in LSBs).
// Optional residual flush is enabled by defining AXIS_PACK_FLUSH_EN.
module axis_pack_24to32 #(
  parameter bit SWAP = 1'b0
) (
  input  logic                     clk,
  input  logic                     reset,
`ifdef AXIS_PACK_FLUSH_EN
  input  logic                     flush,
  output logic                     flush_done,
`endif
  axis_pack_24to32_if.slave        axis,
  output logic [1:0]               phase
);

  logic [1:0]  ph_q, ph_d;
  logic [23:0] res_q, res_d;
  logic        m_valid_q, m_valid_d;
  logic [31:0] m_data_q, m_data_d;

  logic        slot_free;
  logic        s_ready;
  logic        in_hs;
  logic [31:0] packed_word;
  logic [23:0] res_next;

  function automatic logic [31:0] order(input logic [31:0] w);
    return SWAP ? {w[7:0], w[15:8], w[23:16], w[31:24]} : w;
  endfunction

  assign slot_free = ~m_valid_q | axis.m_axis_tready;

`ifdef AXIS_PACK_FLUSH_EN
  logic flush_pending_q, flush_pending_d;
  logic flush_done_q, flush_done_d;
  logic flush_fire;

  assign flush_fire = flush_pending_q & slot_free;
  // A flush request blocks the input in the same cycle so it always wins over a beat.
  assign s_ready    = ~flush & ~flush_pending_q & ((ph_q == 2'd0) | slot_free);
  assign flush_done = flush_done_q;
`else
  assign s_ready    = (ph_q == 2'd0) | slot_free;
`endif

  assign in_hs = axis.s_axis_tvalid & s_ready;

  // Residual is kept zero-extended so a flush can emit it directly as {8'h00, res_q}.
  always_comb begin
    packed_word = '0;
    res_next    = '0;
    case (ph_q)
      2'd0: res_next = axis.s_axis_tdata;
      2'd1: begin
        packed_word = {axis.s_axis_tdata[7:0], res_q};
        res_next    = {8'h00, axis.s_axis_tdata[23:8]};
      end
      2'd2: begin
        packed_word = {axis.s_axis_tdata[15:0], res_q[15:0]};
        res_next    = {16'h0000, axis.s_axis_tdata[23:16]};
      end
      default: packed_word = {axis.s_axis_tdata, res_q[7:0]};
    endcase
  end

  // NOTE: every variable gets a default at the top of the block so no path leaves it unassigned (no latch).
  always_comb begin
    ph_d      = ph_q;
    res_d     = res_q;
    m_valid_d = m_valid_q & ~axis.m_axis_tready;
    m_data_d  = m_data_q;
`ifdef AXIS_PACK_FLUSH_EN
    flush_pending_d = flush_pending_q;
    flush_done_d    = 1'b0;
`endif
    if (in_hs) begin
      ph_d  = ph_q + 2'd1;
      res_d = res_next;
      if (ph_q != 2'd0) begin
        m_valid_d = 1'b1;
        m_data_d  = order(packed_word);
      end
    end
`ifdef AXIS_PACK_FLUSH_EN
    if (flush && !flush_pending_q) begin
      if (ph_q == 2'd0) flush_done_d    = 1'b1;
      else              flush_pending_d = 1'b1;
    end else if (flush_fire) begin
      m_valid_d       = 1'b1;
      m_data_d        = order({8'h00, res_q});
      ph_d            = 2'd0;
      res_d           = '0;
      flush_pending_d = 1'b0;
      flush_done_d    = 1'b1;
    end
`endif
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ph_q      <= 2'd0;
      res_q     <= '0;
      m_valid_q <= 1'b0;
      m_data_q  <= '0;
`ifdef AXIS_PACK_FLUSH_EN
      flush_pending_q <= 1'b0;
      flush_done_q    <= 1'b0;
`endif
    end else begin
      ph_q      <= ph_d;
      res_q     <= res_d;
      m_valid_q <= m_valid_d;
      m_data_q  <= m_data_d;
`ifdef AXIS_PACK_FLUSH_EN
      flush_pending_q <= flush_pending_d;
      flush_done_q    <= flush_done_d;
`endif
    end
  end

  assign axis.s_axis_tready = s_ready;
  assign axis.m_axis_tvalid = m_valid_q;
  assign axis.m_axis_tdata  = m_data_q;
  assign phase              = ph_q;

endmodule

// File: tb/tb_axis_pack_24to32.sv
// Self-checking bench for axis_pack_24to32: SWAP=0 and SWAP=1 instances share one stimulus,
// checked against a byte-queue reference model.
module tb_axis_pack_24to32;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        s_valid = 1'b0;
  logic [23:0] s_data = '0;
  logic        m_ready = 1'b1;
  logic [1:0]  phase0, phase1;

  always #5 clk = ~clk;

  axis_pack_24to32_if if0 ();
  axis_pack_24to32_if if1 ();

  assign if0.s_axis_tvalid = s_valid;
  assign if0.s_axis_tdata  = s_data;
  assign if0.m_axis_tready = m_ready;
  assign if1.s_axis_tvalid = s_valid;
  assign if1.s_axis_tdata  = s_data;
  assign if1.m_axis_tready = m_ready;

`ifdef AXIS_PACK_FLUSH_EN
  logic flush = 1'b0;
  logic flush_done0, flush_done1;
  int   flush_cnt;
`endif

  axis_pack_24to32 #(.SWAP(1'b0)) u_dut0 (
    .clk        (clk),
    .reset      (reset),
`ifdef AXIS_PACK_FLUSH_EN
    .flush      (flush),
    .flush_done (flush_done0),
`endif
    .axis       (if0),
    .phase      (phase0)
  );

  axis_pack_24to32 #(.SWAP(1'b1)) u_dut1 (
    .clk        (clk),
    .reset      (reset),
`ifdef AXIS_PACK_FLUSH_EN
    .flush      (flush),
    .flush_done (flush_done1),
`endif
    .axis       (if1),
    .phase      (phase1)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  // Reference model: a byte stream, 3 bytes in per beat, 4 bytes out per word.
  logic [7:0]  byte_q[$];
  logic [31:0] exp_q0[$], exp_q1[$];
  logic [31:0] got_q0[$], got_q1[$];
  logic [23:0] tx_q[$];
  int          beats;
  int          n_in, n_out;
  logic        in_hs;

  function automatic logic [31:0] bswap(input logic [31:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

  function automatic void model_emit();
    logic [31:0] w;
    for (int i = 0; i < 4; i++) w[8*i +: 8] = byte_q.pop_front();
    exp_q0.push_back(w);
    exp_q1.push_back(bswap(w));
  endfunction

  function automatic void model_push(input logic [23:0] d);
    for (int i = 0; i < 3; i++) byte_q.push_back(d[8*i +: 8]);
    beats++;
    while (byte_q.size() >= 4) model_emit();
  endfunction

  function automatic void model_flush();
    if (byte_q.size() > 0) begin
      while (byte_q.size() < 4) byte_q.push_back(8'h00);
      model_emit();
    end
    beats = 0;
  endfunction

  function automatic void model_clear();
    byte_q.delete();
    exp_q0.delete();
    exp_q1.delete();
    got_q0.delete();
    got_q1.delete();
    beats = 0;
  endfunction

  // Called at a negedge after inputs are set; evaluates this cycle's handshakes, then advances one cycle.
  task automatic step();
    #1;
    in_hs = s_valid && if0.s_axis_tready;
    if (if0.m_axis_tvalid && m_ready) begin
      n_out++;
      check("word0_expected", 32'(exp_q0.size() > 0), 32'd1);
      if (exp_q0.size() > 0) check("word0", if0.m_axis_tdata, exp_q0.pop_front());
      got_q0.push_back(if0.m_axis_tdata);
    end
    if (if1.m_axis_tvalid && m_ready) begin
      check("word1_expected", 32'(exp_q1.size() > 0), 32'd1);
      if (exp_q1.size() > 0) check("word1", if1.m_axis_tdata, exp_q1.pop_front());
      got_q1.push_back(if1.m_axis_tdata);
    end
`ifdef AXIS_PACK_FLUSH_EN
    if (flush_done0) flush_cnt++;
    if (flush) model_flush();
`endif
    if (in_hs) begin
      n_in++;
      model_push(s_data);
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    s_valid = 1'b0;
    m_ready = 1'b1;
    reset   = 1'b1;
    model_clear();
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic send(input int budget, input bit rnd);
    int cyc = 0;
    s_valid = 1'b0;
    while (tx_q.size() > 0 && cyc < budget) begin
      if (!s_valid) s_valid = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
      s_data  = tx_q[0];
      m_ready = rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
      step();
      if (in_hs) begin
        void'(tx_q.pop_front());
        s_valid = 1'b0;
      end
      cyc++;
    end
    s_valid = 1'b0;
    check("send_timeout", 32'(tx_q.size()), 32'd0);
  endtask

  task automatic drain();
    s_valid = 1'b0;
    m_ready = 1'b1;
    for (int i = 0; i < 4; i++) step();
    check("drain_q0", 32'(exp_q0.size()), 32'd0);
    check("drain_q1", 32'(exp_q1.size()), 32'd0);
  endtask

  logic [23:0] stream_beats [4] = '{24'h030201, 24'h060504, 24'h090807, 24'h0C0B0A};

  initial begin
    // Reset state, sampled while reset is held.
    @(negedge clk);
    #1;
    check("rst_tvalid", 32'(if0.m_axis_tvalid), 32'd0);
    check("rst_tdata", if0.m_axis_tdata, 32'd0);
    check("rst_phase", 32'(phase0), 32'd0);
    check("rst_tready", 32'(if0.s_axis_tready), 32'd1);
    do_reset();
    check("post_rst_tready", 32'(if0.s_axis_tready), 32'd1);

    // Streaming, both SWAP settings, with latency check after the word-completing beat.
    n_in = 0; n_out = 0;
    s_valid = 1'b1;
    m_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      s_data = stream_beats[i];
      step();
      if (i == 1) begin
        check("lat_tvalid", 32'(if0.m_axis_tvalid), 32'd1);
        check("lat_tdata", if0.m_axis_tdata, 32'h04030201);
      end
    end
    s_valid = 1'b0;
    step();
    check("stream_in", 32'(n_in), 32'd4);
    check("stream_out", 32'(n_out), 32'd3);
    check("stream_w0", got_q0[0], 32'h04030201);
    check("stream_w1", got_q0[1], 32'h08070605);
    check("stream_w2", got_q0[2], 32'h0C0B0A09);
    check("swap_w0", got_q1[0], 32'h01020304);
    check("swap_w1", got_q1[1], 32'h05060708);
    check("swap_w2", got_q1[2], 32'h090A0B0C);
    check("stream_phase", 32'(phase0), 32'd0);

    // Backpressure: stall after the first word, then random stalls.
    do_reset();
    s_valid = 1'b1;
    m_ready = 1'b1;
    s_data = stream_beats[0]; step();
    s_data = stream_beats[1]; step();
    s_data = stream_beats[2];
    m_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("bp_tready", 32'(if0.s_axis_tready), 32'd0);
      check("bp_tdata", if0.m_axis_tdata, 32'h04030201);
      check("bp_phase", 32'(phase0), 32'd2);
      step();
    end
    tx_q.delete();
    tx_q.push_back(stream_beats[2]);
    tx_q.push_back(stream_beats[3]);
    for (int i = 0; i < 12; i++) tx_q.push_back(24'($urandom));
    n_out = 0;
    send(400, 1'b1);
    drain();
    check("bp_words", 32'(n_out), 32'd12);
    check("bp_phase_end", 32'(phase0), 32'(beats % 4));

    // Sustained throughput.
    do_reset();
    tx_q.delete();
    for (int i = 0; i < 400; i++) tx_q.push_back(24'($urandom));
    n_in = 0; n_out = 0;
    m_ready = 1'b1;
    for (int c = 0; c < 401; c++) begin
      s_valid = tx_q.size() > 0;
      if (s_valid) s_data = tx_q[0];
      step();
      if (in_hs) void'(tx_q.pop_front());
    end
    s_valid = 1'b0;
    check("tput_in", 32'(n_in), 32'd400);
    check("tput_out", 32'(n_out), 32'd300);

    // Reset mid-stream.
    do_reset();
    s_valid = 1'b1;
    s_data = 24'hDEADBE; step();
    s_data = 24'h123456; step();
    s_valid = 1'b0;
    check("pre_mid_tvalid", 32'(if0.m_axis_tvalid), 32'd1);
    reset = 1'b1;
    #1;
    check("mid_rst_tvalid", 32'(if0.m_axis_tvalid), 32'd0);
    check("mid_rst_phase", 32'(phase0), 32'd0);
    model_clear();
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    tx_q.delete();
    for (int i = 0; i < 4; i++) tx_q.push_back(stream_beats[i]);
    send(50, 1'b0);
    drain();
    check("mid_rst_w0", got_q0[0], 32'h04030201);
    check("mid_rst_phase_end", 32'(phase0), 32'd0);

`ifdef AXIS_PACK_FLUSH_EN
    // Flush of a ph2 residual.
    do_reset();
    flush_cnt = 0;
    s_valid = 1'b1;
    s_data = 24'hAABBCC; step();
    s_data = 24'h112233; step();
    s_valid = 1'b0;
    flush = 1'b1; step();
    flush = 1'b0;
    for (int i = 0; i < 4; i++) step();
    check("flush_w0", got_q0[0], 32'h33AABBCC);
    check("flush_w1", got_q0[1], 32'h00001122);
    check("flush_done_cnt", 32'(flush_cnt), 32'd1);
    check("flush_phase", 32'(phase0), 32'd0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
